// File: rtl/switch_io.sv
// switch_io: memory-mapped slide-switch input peripheral. Eight raw pins are
// synchronised and debounced, rising edges are latched into a W1C register, and
// a maskable level interrupt is raised toward the processor. Registers are
// read and written over the shared tristate data bus.
module switch_io #(
   parameter logic [7:0] BaseAddr        = 8'hC4,
   parameter int         DEBOUNCE_CYCLES = 50000,
   parameter int         CNT_W           = 16
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   input  logic [7:0] SW_IN,
   output logic       BUS_INTERRUPT_RAISE,
   input  logic       BUS_INTERRUPT_ACK
);

   // Counter value seen on the last mismatching cycle before the state flips.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0] sync1_reg;
   logic [7:0] sync2_reg;
   logic [7:0] state_reg;
   wire  [7:0] state_next;
   logic [7:0] edge_reg;
   logic [7:0] edge_next;
   logic [7:0] mask_reg;
   logic [7:0] mask_next;
   logic [7:0] pend_prev_reg;
   logic       raise_reg;
   logic       raise_next;
   logic       oe_reg;
   logic       oe_next;
   logic [7:0] rd_data_reg;
   logic [7:0] rd_data_next;

   logic [7:0] offset;
   logic       in_range;
   logic       wr_edge;
   logic       wr_mask;
   logic [7:0] rise;
   logic [7:0] pending;
   logic       pend_rise;

   // Address decode relative to the base; wraps naturally in 8 bits.
   assign offset   = BUS_ADDR - BaseAddr;
   assign in_range = (offset < 8'd3);
   assign wr_edge  = BUS_WE && in_range && (offset == 8'd1);
   assign wr_mask  = BUS_WE && in_range && (offset == 8'd2);

   // The bus is driven only during the cycle after an in-range read.
   assign BUS_DATA = oe_reg ? rd_data_reg : 8'hzz;
   assign BUS_INTERRUPT_RAISE = raise_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_deb
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             bit_next;

         // Count consecutive mismatching cycles; flip the state on the last one.
         always_comb begin
            cnt_next = '0;
            bit_next = state_reg[gi];
            if (sync2_reg[gi] != state_reg[gi]) begin
               if (cnt_reg == CNT_LAST) begin
                  bit_next = sync2_reg[gi];
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end

         assign state_next[gi] = bit_next;

         // Debounce counter register for this bit.
         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end
      end
   endgenerate

   assign rise      = state_next & ~state_reg;
   assign pending   = edge_reg & mask_reg;
   assign pend_rise = |(pending & ~pend_prev_reg);

   // Register updates from the bus; a new edge capture overrides a W1C.
   always_comb begin
      edge_next = edge_reg;
      mask_next = mask_reg;
      if (wr_edge) begin
         edge_next = edge_reg & ~BUS_DATA;
      end
      edge_next = edge_next | rise;
      if (wr_mask) begin
         mask_next = BUS_DATA;
      end
   end

   // Interrupt level: a newly pending bit beats a coincident acknowledge.
   always_comb begin
      raise_next = raise_reg;
      if (pend_rise) begin
         raise_next = 1'b1;
      end else if (BUS_INTERRUPT_ACK) begin
         raise_next = 1'b0;
      end
   end

   // Read slot: enable the driver and capture the addressed register.
   always_comb begin
      oe_next = in_range && !BUS_WE;
      case (offset)
         8'd0:    rd_data_next = state_reg;
         8'd1:    rd_data_next = edge_reg;
         8'd2:    rd_data_next = mask_reg;
         default: rd_data_next = 8'h00;
      endcase
   end

   // Peripheral state registers, cleared asynchronously by reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync1_reg     <= 8'h00;
         sync2_reg     <= 8'h00;
         state_reg     <= 8'h00;
         edge_reg      <= 8'h00;
         mask_reg      <= 8'h00;
         pend_prev_reg <= 8'h00;
         raise_reg     <= 1'b0;
         oe_reg        <= 1'b0;
         rd_data_reg   <= 8'h00;
      end else begin
         sync1_reg     <= SW_IN;
         sync2_reg     <= sync1_reg;
         state_reg     <= state_next;
         edge_reg      <= edge_next;
         mask_reg      <= mask_next;
         pend_prev_reg <= pending;
         raise_reg     <= raise_next;
         oe_reg        <= oe_next;
         rd_data_reg   <= rd_data_next;
      end
   end

endmodule

// File: tb/tb_switch_io.sv
// tb_switch_io: directed bench for switch_io with a cycle-tagged scoreboard.
// Stimulus pushes expected bus reads and interrupt levels; a monitor on the
// falling edge pops the entries due that cycle and checks the idle bus otherwise.
module tb_switch_io;

   localparam logic [7:0] IDLE = 8'hFF;   // value of the pulled-up bus when undriven

   typedef struct {
      int         due;
      bit         kind;     // 0 = bus read data, 1 = interrupt level
      logic [7:0] exp;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] bus_addr;
   logic       bus_we;
   logic [7:0] sw_in;
   logic       raise;
   logic       ack;
   logic [7:0] tb_drv;
   logic       tb_drv_en;
   tri1  [7:0] bus_data;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   assign bus_data = tb_drv_en ? tb_drv : 8'hzz;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   switch_io #(
      .BaseAddr       (8'hC4),
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (16)
   ) dut (
      .CLK                (clk),
      .RESET              (rst_n),
      .BUS_DATA           (bus_data),
      .BUS_ADDR           (bus_addr),
      .BUS_WE             (bus_we),
      .SW_IN              (sw_in),
      .BUS_INTERRUPT_RAISE(raise),
      .BUS_INTERRUPT_ACK  (ack)
   );

   // Monitor: compare every entry due this cycle, otherwise require an idle bus.
   exp_t keep_q[$];
   bit   bus_seen;
   always @(negedge clk) begin
      bus_seen = 1'b0;
      keep_q   = {};
      foreach (exp_q[i]) begin
         if (exp_q[i].due == cyc) begin
            checks++;
            if (exp_q[i].kind == 1'b0) begin
               bus_seen = 1'b1;
               if (bus_data !== exp_q[i].exp) begin
                  errors++;
                  $display("FAIL %s: bus=%h required=%h (cycle %0d)", exp_q[i].name, bus_data, exp_q[i].exp, cyc);
               end else begin
                  $display("read  %-16s bus=%h ok (cycle %0d)", exp_q[i].name, bus_data, cyc);
               end
            end else begin
               if (raise !== exp_q[i].exp[0]) begin
                  errors++;
                  $display("FAIL %s: raise=%b required=%b (cycle %0d)", exp_q[i].name, raise, exp_q[i].exp[0], cyc);
               end else begin
                  $display("irq   %-16s raise=%b ok (cycle %0d)", exp_q[i].name, raise, cyc);
               end
            end
         end else if (exp_q[i].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: entry never checked, due=%0d now=%0d", exp_q[i].name, exp_q[i].due, cyc);
         end else begin
            keep_q.push_back(exp_q[i]);
         end
      end
      exp_q = keep_q;
      if (!bus_seen && !tb_drv_en) begin
         checks++;
         if (bus_data !== IDLE) begin
            errors++;
            $display("FAIL idle_bus: bus=%h required=%h (undriven) (cycle %0d)", bus_data, IDLE, cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic expect_raise(input logic v, input string nm);
      exp_t e;
      e.due = cyc; e.kind = 1'b1; e.exp = {7'd0, v}; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] ev, input string nm);
      exp_t e;
      bus_addr = a;
      bus_we   = 1'b0;
      e.due = cyc + 1; e.kind = 1'b0; e.exp = ev; e.name = nm;
      exp_q.push_back(e);
      tick();
      bus_addr = 8'h00;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus_addr  = a;
      bus_we    = 1'b1;
      tb_drv    = d;
      tb_drv_en = 1'b1;
      $display("write addr=%h data=%h (cycle %0d)", a, d, cyc + 1);
      tick();
      bus_we    = 1'b0;
      tb_drv_en = 1'b0;
      bus_addr  = 8'h00;
   endtask

   initial begin
      exp_t e;
      rst_n     = 1'b0;
      bus_addr  = 8'h00;
      bus_we    = 1'b0;
      sw_in     = 8'h00;
      ack       = 1'b0;
      tb_drv    = 8'h00;
      tb_drv_en = 1'b0;
      ticks(3);
      rst_n = 1'b1;

      // Reset values
      expect_raise(1'b0, "rst_raise");
      rd(8'hC4, 8'h00, "rst_state");
      rd(8'hC5, 8'h00, "rst_edge");
      rd(8'hC6, 8'h00, "rst_mask");

      // Clean press: STATE flips on the sixth edge
      sw_in = 8'h01;
      ticks(5);
      rd(8'hC4, 8'h00, "press_pre");
      rd(8'hC4, 8'h01, "press_state");
      rd(8'hC5, 8'h01, "press_edge");
      expect_raise(1'b0, "press_nomask");
      sw_in = 8'h00;
      ticks(8);
      wr(8'hC5, 8'h01);
      rd(8'hC5, 8'h00, "w1c_clr");

      // Bounce on bit 3: 3-cycle pulses never debounce
      tick();
      wr(8'hC6, 8'h08);
      rd(8'hC6, 8'h08, "mask08");
      for (int i = 0; i < 40; i++) begin
         sw_in[3] = ((i / 3) % 2) == 0;
         tick();
      end
      sw_in = 8'h00;
      ticks(6);
      rd(8'hC4, 8'h00, "bounce_state");
      rd(8'hC5, 8'h00, "bounce_edge");
      expect_raise(1'b0, "bounce_raise");

      // Interrupt flow
      tick();
      wr(8'hC6, 8'h01);
      rd(8'hC6, 8'h01, "mask01");
      sw_in = 8'h01;
      ticks(6);
      expect_raise(1'b0, "irq_pre");
      rd(8'hC5, 8'h01, "irq_edge");
      expect_raise(1'b1, "irq_raise");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      expect_raise(1'b0, "irq_ack");
      wr(8'hC5, 8'h01);
      rd(8'hC5, 8'h00, "irq_w1c");
      expect_raise(1'b0, "irq_stay_low");
      sw_in = 8'h00;
      ticks(8);

      // Collision: W1C on the capture edge, capture wins
      sw_in = 8'h01;
      ticks(5);
      wr(8'hC5, 8'h01);
      rd(8'hC5, 8'h01, "coll_w1c");
      expect_raise(1'b1, "coll_w1c_raise");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      expect_raise(1'b0, "coll_ack1");

      // Collision: ACK together with a newly exposed pending bit
      sw_in = 8'h03;
      ticks(8);
      expect_raise(1'b0, "mask_hides");
      rd(8'hC5, 8'h03, "edge_b1");
      tick();
      wr(8'hC6, 8'h03);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      expect_raise(1'b1, "coll_ack_raise");
      wr(8'hC6, 8'h00);
      expect_raise(1'b1, "mask_clr_keeps");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      expect_raise(1'b0, "coll_ack2");

      // Decode
      wr(8'hC4, 8'hFF);
      rd(8'hC4, 8'h03, "ro_state");
      rd(8'hC7, IDLE, "dec_c7");
      rd(8'hC0, IDLE, "dec_c0");
      tick();
      wr(8'hC6, 8'h00);
      rd(8'hC6, 8'h00, "we_no_drive");

      // Reset mid-read with the interrupt raised
      tick();
      wr(8'hC6, 8'h03);
      tick();
      expect_raise(1'b1, "pre_rst_raise");
      bus_addr = 8'hC4;
      bus_we   = 1'b0;
      e.due = cyc + 1; e.kind = 1'b0; e.exp = IDLE; e.name = "rst_rd_abort";
      exp_q.push_back(e);
      e.due = cyc + 1; e.kind = 1'b1; e.exp = 8'h00; e.name = "rst_raise_async";
      exp_q.push_back(e);
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      bus_addr = 8'h00;
      ticks(2);
      rst_n = 1'b1;
      rd(8'hC4, 8'h00, "rst2_state");
      rd(8'hC5, 8'h00, "rst2_edge");
      rd(8'hC6, 8'h00, "rst2_mask");
      ticks(3);
      rd(8'hC4, 8'h03, "held_state");
      rd(8'hC5, 8'h03, "held_edge");
      expect_raise(1'b0, "held_nomask");
      ticks(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
